ppi_sync_ports: RTL and testbench

Clocked, parametrised successor to the combinational 8255-style PPI. It provides NUM_PORTS general-purpose ports of DATA_W bits each, with per-port direction set by a control word. Bit set/reset (BSR) targets the last port. Port 0 adds a strobed handshake mode (8255 mode-1 style) with IBF/OBF_N/INTR. It sits between the CPU-side bus (CS_N/RD_N/WR_N/A) and the external device pins; all state is registered on CLK.

---
 rtl/ppi_sync_ports.sv | 266 ++++++++++++++++++++++++++
 tb/tb_ppi_sync_ports.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ppi_sync_ports.sv
`default_nettype none
// ============================================================================
// Module      : ppi_sync_ports
// Description : Clocked 8255-style parallel port block with NUM_PORTS ports,
//               per-port direction, bit set/reset on the last port and a
//               strobed handshake on port 0 (IBF / OBF_N / INTR).
//               Optional macro PPI_INPUT_SYNC_EN adds 2-flop synchronisers
//               on P_IN, STB_N and ACK_N.
// Revision    : 1.0 - initial release
// ============================================================================
module ppi_sync_ports #(
    parameter int DATA_W    = 8,
    parameter int NUM_PORTS = 3,
    parameter int ADDR_W    = 3
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          CS_N,
    input  logic                          RD_N,
    input  logic                          WR_N,
    input  logic [ADDR_W-1:0]             A,
    input  logic [DATA_W-1:0]             DIN,
    output logic [DATA_W-1:0]             DOUT,
    output logic                          DOUT_EN,
    input  logic [NUM_PORTS*DATA_W-1:0]   P_IN,
    output logic [NUM_PORTS*DATA_W-1:0]   P_OUT,
    output logic [NUM_PORTS-1:0]          P_OE,
    input  logic                          STB_N,
    input  logic                          ACK_N,
    output logic                          IBF,
    output logic                          OBF_N,
    output logic                          INTR
);

    localparam int c_pin_w    = NUM_PORTS * DATA_W;
    localparam int c_bsr_base = (NUM_PORTS - 1) * DATA_W;

    // ------------------------------------------------------------------------
    // Pin front-end
    // ------------------------------------------------------------------------
    logic [c_pin_w-1:0] w_pin;
    logic               w_stb_n;
    logic               w_ack_n;

`ifdef PPI_INPUT_SYNC_EN
    logic [c_pin_w-1:0] pin_m1_q, pin_m1_d;
    logic [c_pin_w-1:0] pin_m2_q, pin_m2_d;
    logic [1:0]         hs_m1_q, hs_m1_d;
    logic [1:0]         hs_m2_q, hs_m2_d;

    always_comb begin
        pin_m1_d = P_IN;
        pin_m2_d = pin_m1_q;
        hs_m1_d  = {ACK_N, STB_N};
        hs_m2_d  = hs_m1_q;
    end

    // Reset to the asserted-low level so a strobe held low through reset
    // never appears as a fresh falling edge downstream.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pin_m1_q <= '0;
            pin_m2_q <= '0;
            hs_m1_q  <= '0;
            hs_m2_q  <= '0;
        end else begin
            pin_m1_q <= pin_m1_d;
            pin_m2_q <= pin_m2_d;
            hs_m1_q  <= hs_m1_d;
            hs_m2_q  <= hs_m2_d;
        end
    end

    assign w_pin   = pin_m2_q;
    assign w_stb_n = hs_m2_q[0];
    assign w_ack_n = hs_m2_q[1];
`else
    assign w_pin   = P_IN;
    assign w_stb_n = STB_N;
    assign w_ack_n = ACK_N;
`endif

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [NUM_PORTS-1:0] dir_q,       dir_d;
    logic                 strobe_en_q, strobe_en_d;
    logic [c_pin_w-1:0]   pout_q,      pout_d;
    logic [c_pin_w-1:0]   pin_s_q,     pin_s_d;
    logic [DATA_W-1:0]    latch_q,     latch_d;
    logic [DATA_W-1:0]    dout_q,      dout_d;
    logic                 dout_en_q,   dout_en_d;
    logic                 ibf_q,       ibf_d;
    logic                 obf_n_q,     obf_n_d;
    logic                 written_q,   written_d;
    logic                 wr_act_q,    wr_act_d;
    logic                 rd_act_q,    rd_act_d;
    logic                 rd0_q,       rd0_d;
    logic                 stb_s_q,     stb_s_d;
    logic                 stb_prev_q,  stb_prev_d;
    logic                 ack_s_q,     ack_s_d;
    logic                 ack_prev_q,  ack_prev_d;

    logic                 w_wr_act;
    logic                 w_rd_act;
    logic                 w_wr_fire;
    logic                 w_rd0_end;
    logic                 w_stb_fall;
    logic                 w_ack_fall;
    logic                 w_strobe_in;
    logic                 w_strobe_out;
    logic [DATA_W-1:0]    w_rd_val;

    assign w_wr_act     = ~CS_N & ~WR_N;
    assign w_rd_act     = ~CS_N & ~RD_N;
    assign w_wr_fire    = w_wr_act & ~wr_act_q;
    assign w_rd0_end    = rd0_q & ~w_rd_act;
    assign w_stb_fall   = stb_prev_q & ~stb_s_q;
    assign w_ack_fall   = ack_prev_q & ~ack_s_q;
    assign w_strobe_in  = strobe_en_q &  dir_q[0];
    assign w_strobe_out = strobe_en_q & ~dir_q[0];

    // ------------------------------------------------------------------------
    // Read data selection
    // ------------------------------------------------------------------------
    always_comb begin
        w_rd_val = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (int'(A) == k) begin
                if (!dir_q[k]) begin
                    w_rd_val = pout_q[k*DATA_W +: DATA_W];
                end else if (k == 0 && strobe_en_q) begin
                    w_rd_val = latch_q;
                end else begin
                    w_rd_val = pin_s_q[k*DATA_W +: DATA_W];
                end
            end
        end
        if (int'(A) == NUM_PORTS) begin
            w_rd_val[7]             = 1'b1;
            w_rd_val[6]             = strobe_en_q;
            w_rd_val[NUM_PORTS-1:0] = dir_q;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        dir_d       = dir_q;
        strobe_en_d = strobe_en_q;
        pout_d      = pout_q;
        latch_d     = latch_q;
        ibf_d       = ibf_q;
        obf_n_d     = obf_n_q;
        written_d   = written_q;
        dout_d      = w_rd_act ? w_rd_val : dout_q;
        dout_en_d   = w_rd_act;
        wr_act_d    = w_wr_act;
        rd_act_d    = w_rd_act;
        rd0_d       = w_rd_act & (A == '0);
        pin_s_d     = w_pin;
        stb_s_d     = w_stb_n;
        stb_prev_d  = stb_s_q;
        ack_s_d     = w_ack_n;
        ack_prev_d  = ack_s_q;

        // Strobe is evaluated after read-end so it wins a same-cycle collision.
        if (w_strobe_in) begin
            if (w_rd0_end) begin
                ibf_d = 1'b0;
            end
            if (w_stb_fall) begin
                ibf_d   = 1'b1;
                latch_d = pin_s_q[DATA_W-1:0];
            end
        end

        if (w_strobe_out && w_ack_fall) begin
            obf_n_d = 1'b1;
        end

        if (w_wr_fire) begin
            if (int'(A) < NUM_PORTS) begin
                for (int k = 0; k < NUM_PORTS; k++) begin
                    if (int'(A) == k) begin
                        pout_d[k*DATA_W +: DATA_W] = DIN;
                    end
                end
                // Write overrides an ACK arriving in the same cycle.
                if (A == '0 && w_strobe_out) begin
                    obf_n_d   = 1'b0;
                    written_d = 1'b1;
                end
            end else if (int'(A) == NUM_PORTS) begin
                if (DIN[7]) begin
                    dir_d       = DIN[NUM_PORTS-1:0];
                    strobe_en_d = DIN[6];
                    pout_d      = '0;
                    ibf_d       = 1'b0;
                    obf_n_d     = 1'b1;
                    written_d   = 1'b0;
                end else begin
                    for (int b = 0; b < DATA_W; b++) begin
                        if (int'(DIN[6:1]) == b) begin
                            pout_d[c_bsr_base + b] = DIN[0];
                        end
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            dir_q       <= '1;
            strobe_en_q <= 1'b0;
            pout_q      <= '0;
            latch_q     <= '0;
            ibf_q       <= 1'b0;
            obf_n_q     <= 1'b1;
            written_q   <= 1'b0;
            dout_q      <= '0;
            dout_en_q   <= 1'b0;
            wr_act_q    <= 1'b0;
            rd_act_q    <= 1'b0;
            rd0_q       <= 1'b0;
            pin_s_q     <= '0;
            stb_s_q     <= 1'b0;
            stb_prev_q  <= 1'b0;
            ack_s_q     <= 1'b0;
            ack_prev_q  <= 1'b0;
        end else begin
            dir_q       <= dir_d;
            strobe_en_q <= strobe_en_d;
            pout_q      <= pout_d;
            latch_q     <= latch_d;
            ibf_q       <= ibf_d;
            obf_n_q     <= obf_n_d;
            written_q   <= written_d;
            dout_q      <= dout_d;
            dout_en_q   <= dout_en_d;
            wr_act_q    <= wr_act_d;
            rd_act_q    <= rd_act_d;
            rd0_q       <= rd0_d;
            pin_s_q     <= pin_s_d;
            stb_s_q     <= stb_s_d;
            stb_prev_q  <= stb_prev_d;
            ack_s_q     <= ack_s_d;
            ack_prev_q  <= ack_prev_d;
        end
    end

    assign P_OUT   = pout_q;
    assign P_OE    = ~dir_q;
    assign DOUT    = dout_q;
    assign DOUT_EN = dout_en_q;
    assign IBF     = ibf_q;
    assign OBF_N   = obf_n_q;
    assign INTR    = strobe_en_q & (dir_q[0] ? ibf_q : (obf_n_q & written_q));

endmodule
`default_nettype wire

// File: tb/tb_ppi_sync_ports.sv
`default_nettype none
// ============================================================================
// Module      : tb_ppi_sync_ports
// Description : Self-checking bench for ppi_sync_ports (default build).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ppi_sync_ports;

    localparam int OP_WR   = 0;
    localparam int OP_RD   = 1;
    localparam int OP_PIN  = 2;
    localparam int OP_CKP  = 3;
    localparam int OP_CKOE = 4;

    typedef struct {
        int          op;
        logic [2:0]  a;
        logic [7:0]  d;
        logic [23:0] pin;
        logic [7:0]  exp;
    } vec_t;

    logic        CLK = 1'b0;
    logic        RST, CS_N, RD_N, WR_N, STB_N, ACK_N;
    logic [2:0]  A;
    logic [7:0]  DIN, DOUT;
    logic        DOUT_EN, IBF, OBF_N, INTR;
    logic [23:0] P_IN, P_OUT;
    logic [2:0]  P_OE;

    int          checks   = 0;
    int          failures = 0;
    logic [7:0]  exp_q[$];
    vec_t        tbl[$];

    ppi_sync_ports #(.DATA_W(8), .NUM_PORTS(3), .ADDR_W(3)) dut (
        .CLK(CLK), .RST(RST), .CS_N(CS_N), .RD_N(RD_N), .WR_N(WR_N),
        .A(A), .DIN(DIN), .DOUT(DOUT), .DOUT_EN(DOUT_EN),
        .P_IN(P_IN), .P_OUT(P_OUT), .P_OE(P_OE),
        .STB_N(STB_N), .ACK_N(ACK_N), .IBF(IBF), .OBF_N(OBF_N), .INTR(INTR)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_write(input logic [2:0] a, input logic [7:0] d);
        CS_N = 1'b0; WR_N = 1'b0; A = a; DIN = d;
        tick();
        WR_N = 1'b1; CS_N = 1'b1;
        tick();
    endtask

    task automatic do_read(input logic [2:0] a, input logic [7:0] e);
        CS_N = 1'b0; RD_N = 1'b0; A = a;
        exp_q.push_back(e);
        tick();
        RD_N = 1'b1; CS_N = 1'b1;
        tick();
        tick();
    endtask

    // Read-data scoreboard: every bus cycle with DOUT_EN consumes one expectation.
    always @(negedge CLK) begin
        if (DOUT_EN === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("dout_unexpected", 64'd1, 64'd0);
            end else begin
                check("dout", DOUT, exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1; CS_N = 1'b1; RD_N = 1'b1; WR_N = 1'b1;
        STB_N = 1'b1; ACK_N = 1'b1; A = '0; DIN = '0; P_IN = '0;
        repeat (3) tick();
        RST = 1'b0;
        tick();

        check("rst_pout",    P_OUT,   24'h0);
        check("rst_poe",     P_OE,    3'b000);
        check("rst_ibf",     IBF,     1'b0);
        check("rst_obf_n",   OBF_N,   1'b1);
        check("rst_intr",    INTR,    1'b0);
        check("rst_dout_en", DOUT_EN, 1'b0);
        check("rst_dout",    DOUT,    8'h00);

        tbl.push_back(vec_t'{OP_RD,   3'd3, 8'h00, 24'h0,      8'h87});
        tbl.push_back(vec_t'{OP_WR,   3'd3, 8'h84, 24'h0,      8'h00});
        tbl.push_back(vec_t'{OP_WR,   3'd0, 8'h55, 24'h0,      8'h00});
        tbl.push_back(vec_t'{OP_WR,   3'd1, 8'hAA, 24'h0,      8'h00});
        tbl.push_back(vec_t'{OP_PIN,  3'd0, 8'h00, 24'h3C0000, 8'h00});
        tbl.push_back(vec_t'{OP_CKP,  3'd0, 8'h00, 24'h0,      8'h55});
        tbl.push_back(vec_t'{OP_CKP,  3'd1, 8'h00, 24'h0,      8'hAA});
        tbl.push_back(vec_t'{OP_CKOE, 3'd0, 8'h00, 24'h0,      8'h03});
        tbl.push_back(vec_t'{OP_RD,   3'd2, 8'h00, 24'h0,      8'h3C});
        tbl.push_back(vec_t'{OP_RD,   3'd0, 8'h00, 24'h0,      8'h55});
        tbl.push_back(vec_t'{OP_RD,   3'd3, 8'h00, 24'h0,      8'h84});
        tbl.push_back(vec_t'{OP_WR,   3'd2, 8'h77, 24'h0,      8'h00});
        tbl.push_back(vec_t'{OP_CKP,  3'd2, 8'h00, 24'h0,      8'h77});
        tbl.push_back(vec_t'{OP_RD,   3'd2, 8'h00, 24'h0,      8'h3C});
        tbl.push_back(vec_t'{OP_WR,   3'd5, 8'hFF, 24'h0,      8'h00});
        tbl.push_back(vec_t'{OP_CKP,  3'd0, 8'h00, 24'h0,      8'h55});
        tbl.push_back(vec_t'{OP_CKP,  3'd1, 8'h00, 24'h0,      8'hAA});
        tbl.push_back(vec_t'{OP_RD,   3'd5, 8'h00, 24'h0,      8'h00});
        tbl.push_back(vec_t'{OP_RD,   3'd4, 8'h00, 24'h0,      8'h00});
        tbl.push_back(vec_t'{OP_WR,   3'd3, 8'h80, 24'h0,      8'h00});
        tbl.push_back(vec_t'{OP_CKP,  3'd0, 8'h00, 24'h0,      8'h00});
        tbl.push_back(vec_t'{OP_CKP,  3'd2, 8'h00, 24'h0,      8'h00});
        tbl.push_back(vec_t'{OP_CKOE, 3'd0, 8'h00, 24'h0,      8'h07});
        tbl.push_back(vec_t'{OP_WR,   3'd3, 8'h0B, 24'h0,      8'h00});
        tbl.push_back(vec_t'{OP_CKP,  3'd2, 8'h00, 24'h0,      8'h20});
        tbl.push_back(vec_t'{OP_WR,   3'd3, 8'h01, 24'h0,      8'h00});
        tbl.push_back(vec_t'{OP_CKP,  3'd2, 8'h00, 24'h0,      8'h21});
        tbl.push_back(vec_t'{OP_WR,   3'd3, 8'h0A, 24'h0,      8'h00});
        tbl.push_back(vec_t'{OP_CKP,  3'd2, 8'h00, 24'h0,      8'h01});
        tbl.push_back(vec_t'{OP_WR,   3'd3, 8'h11, 24'h0,      8'h00});
        tbl.push_back(vec_t'{OP_CKP,  3'd2, 8'h00, 24'h0,      8'h01});
        tbl.push_back(vec_t'{OP_CKOE, 3'd0, 8'h00, 24'h0,      8'h07});
        tbl.push_back(vec_t'{OP_RD,   3'd3, 8'h00, 24'h0,      8'h80});
        tbl.push_back(vec_t'{OP_RD,   3'd2, 8'h00, 24'h0,      8'h01});

        foreach (tbl[i]) begin
            case (tbl[i].op)
                OP_WR:  do_write(tbl[i].a, tbl[i].d);
                OP_RD:  do_read(tbl[i].a, tbl[i].exp);
                OP_PIN: begin P_IN = tbl[i].pin; tick(); end
                OP_CKP: check($sformatf("pout%0d_v%0d", tbl[i].a, i),
                              P_OUT[int'(tbl[i].a)*8 +: 8], tbl[i].exp);
                default: check($sformatf("poe_v%0d", i), P_OE, tbl[i].exp[2:0]);
            endcase
        end

        // Held write strobe must only load once.
        CS_N = 1'b0; WR_N = 1'b0; A = 3'd0; DIN = 8'h12;
        tick();
        DIN = 8'h34;
        repeat (4) tick();
        WR_N = 1'b1; CS_N = 1'b1;
        tick();
        check("held_write", P_OUT[7:0], 8'h12);

        // Plain input mode: STB_N ignored, read returns sampled pin.
        do_write(3'd3, 8'h81);
        P_IN = 24'h000066;
        tick();
        STB_N = 1'b0; tick(); STB_N = 1'b1; tick(); tick();
        check("nostb_ibf",  IBF,  1'b0);
        check("nostb_intr", INTR, 1'b0);
        do_read(3'd0, 8'h66);

        // Strobed input.
        do_write(3'd3, 8'hC1);
        P_IN = 24'h00009E;
        tick();
        STB_N = 1'b0; tick(); STB_N = 1'b1; tick();
        P_IN = 24'h000000;
        tick();
        check("stb_ibf",  IBF,  1'b1);
        check("stb_intr", INTR, 1'b1);
        CS_N = 1'b0; RD_N = 1'b0; A = 3'd0;
        exp_q.push_back(8'h9E);
        tick();
        check("ibf_during_read", IBF, 1'b1);
        RD_N = 1'b1; CS_N = 1'b1;
        tick();
        check("ibf_after_read",  IBF,  1'b0);
        check("intr_after_read", INTR, 1'b0);
        tick();

        // Strobe falling edge coincides with read end: strobe wins.
        CS_N = 1'b0; RD_N = 1'b0; A = 3'd0; STB_N = 1'b0; P_IN = 24'h00005A;
        exp_q.push_back(8'h9E);
        tick();
        RD_N = 1'b1; CS_N = 1'b1; STB_N = 1'b1;
        tick();
        check("collide_ibf", IBF, 1'b1);
        tick();
        do_read(3'd0, 8'h5A);
        check("collide_ibf_clr", IBF, 1'b0);

        // Strobed output.
        do_write(3'd3, 8'hC0);
        check("out_obf_init",  OBF_N, 1'b1);
        check("out_intr_init", INTR,  1'b0);
        do_write(3'd0, 8'h11);
        check("out_pout0",  P_OUT[7:0], 8'h11);
        check("out_obf_wr", OBF_N, 1'b0);
        check("out_intr_wr", INTR, 1'b0);
        ACK_N = 1'b0; tick(); ACK_N = 1'b1; tick(); tick();
        check("out_obf_ack",  OBF_N, 1'b1);
        check("out_intr_ack", INTR,  1'b1);

        // Write and ACK falling edge in the same cycle: write wins.
        ACK_N = 1'b0;
        tick();
        CS_N = 1'b0; WR_N = 1'b0; A = 3'd0; DIN = 8'h22; ACK_N = 1'b1;
        tick();
        WR_N = 1'b1; CS_N = 1'b1;
        tick();
        check("wrack_obf",   OBF_N,      1'b0);
        check("wrack_intr",  INTR,       1'b0);
        check("wrack_pout0", P_OUT[7:0], 8'h22);

        // Reset mid-handshake with strobes held low.
        ACK_N = 1'b0; STB_N = 1'b0; RST = 1'b1;
        repeat (2) tick();
        RST = 1'b0;
        tick();
        check("mrst_pout",    P_OUT,   24'h0);
        check("mrst_poe",     P_OE,    3'b000);
        check("mrst_dout",    DOUT,    8'h00);
        check("mrst_dout_en", DOUT_EN, 1'b0);
        check("mrst_ibf",     IBF,     1'b0);
        check("mrst_obf_n",   OBF_N,   1'b1);
        check("mrst_intr",    INTR,    1'b0);
        do_write(3'd3, 8'hC1);
        tick(); tick();
        check("held_stb_ibf", IBF, 1'b0);
        STB_N = 1'b1; ACK_N = 1'b1;
        tick(); tick();
        check("held_stb_rise", IBF, 1'b0);
        do_read(3'd3, 8'hC1);

        check("sb_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
